twiddle_cmul: RTL and testbench

//  Consumer end of the twiddle interface: multiplies each R22SDF stage-output sample by the current

---
 rtl/twiddle_cmul_pkg.sv | 13 +
 rtl/twiddle_cmul_sat.sv | 39 +++
 rtl/twiddle_cmul.sv | 156 +++++++++++++++
 tb/tb_twiddle_cmul.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_cmul_pkg.sv
// Shared constants and types for the twiddle complex multiplier: Q2.15 twiddle format and FSM states.
package twiddle_cmul_pkg;

  localparam int unsigned TW_W    = 17;
  localparam int unsigned TW_FRAC = 15;
  localparam int          TW_ONE  = 32768;

  typedef enum logic {
    WAIT_TW = 1'b0,
    RUN     = 1'b1
  } state_e;

endpackage

// File: rtl/twiddle_cmul_sat.sv
// cmul_sat: scale by >>> SHIFT, optional round-half-up (TWIDDLE_CMUL_ROUND_EN), saturate to OUT_W.
module cmul_sat #(
  parameter int unsigned IN_W  = 34,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  sum_i,
  output logic signed [OUT_W-1:0] sat_c,
  output logic                    clip_c
);

  // One guard bit so the rounding add can never wrap.
  localparam int unsigned EW = IN_W + 1;
  localparam logic signed [EW-1:0] SAT_MAX = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef TWIDDLE_CMUL_ROUND_EN
  localparam logic signed [EW-1:0] RND = EW'(64'sd1 <<< (SHIFT - 1));
`else
  localparam logic signed [EW-1:0] RND = '0;
`endif

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shf;

  always_comb begin
    ext    = EW'(sum_i) + RND;
    shf    = ext >>> SHIFT;
    clip_c = 1'b0;
    sat_c  = OUT_W'(shf);
    if (shf > SAT_MAX) begin
      sat_c  = OUT_W'(SAT_MAX);
      clip_c = 1'b1;
    end else if (shf < SAT_MIN) begin
      sat_c  = OUT_W'(SAT_MIN);
      clip_c = 1'b1;
    end
  end

endmodule

// File: rtl/twiddle_cmul.sv
// Twiddle complex multiplier: dout = din * tw, 4-stage pipeline gated by sys_en and cordic_rdy.
// Build option: TWIDDLE_CMUL_ROUND_EN selects round-half-up instead of floor in the final scale.
module twiddle_cmul
  import twiddle_cmul_pkg::*;
#(
  parameter int unsigned data_bw    = 16,
  parameter int unsigned fft_length = 16,
  parameter int unsigned align_dly  = 0
) (
  input  logic                      sys_clk,
  input  logic                      sys_nrst,
  input  logic                      sys_en,
  input  logic signed [data_bw-1:0] din_r,
  input  logic signed [data_bw-1:0] din_i,
  input  logic                      din_vld,
  input  logic signed [TW_W-1:0]    tw_fac_r,
  input  logic signed [TW_W-1:0]    tw_fac_i,
  input  logic                      cordic_rdy,
  output logic signed [data_bw-1:0] dout_r,
  output logic signed [data_bw-1:0] dout_i,
  output logic                      dout_vld,
  output logic                      dout_sof,
  output logic                      ovf_flag
);

  localparam int unsigned PW    = data_bw + TW_W;
  localparam int unsigned SW    = PW + 1;
  localparam int unsigned CNT_W = (fft_length > 1) ? $clog2(fft_length) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(fft_length - 1);

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (sys_en && cordic_rdy && (state_q == WAIT_TW)) state_d = RUN;
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) state_q <= WAIT_TW;
    else           state_q <= state_d;
  end

  logic vld_in;
  assign vld_in = din_vld & (state_q == RUN);

  logic signed [data_bw-1:0] al_r, al_i;
  logic                      al_vld;

  // Optional input delay so din lines up with a twiddle source of matching latency.
  if (align_dly == 0) begin : g_no_align
    assign al_r   = din_r;
    assign al_i   = din_i;
    assign al_vld = vld_in;
  end else begin : g_align
    logic signed [data_bw-1:0] dr_q [align_dly];
    logic signed [data_bw-1:0] di_q [align_dly];
    logic                      dv_q [align_dly];
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
        for (int k = 0; k < int'(align_dly); k++) begin
          dr_q[k] <= '0;
          di_q[k] <= '0;
          dv_q[k] <= 1'b0;
        end
      end else if (sys_en) begin
        dr_q[0] <= din_r;
        di_q[0] <= din_i;
        dv_q[0] <= vld_in;
        for (int k = 1; k < int'(align_dly); k++) begin
          dr_q[k] <= dr_q[k-1];
          di_q[k] <= di_q[k-1];
          dv_q[k] <= dv_q[k-1];
        end
      end
    end
    assign al_r   = dr_q[align_dly-1];
    assign al_i   = di_q[align_dly-1];
    assign al_vld = dv_q[align_dly-1];
  end

  logic signed [data_bw-1:0] ar_q, ai_q;
  logic signed [TW_W-1:0]    br_q, bi_q;
  logic signed [PW-1:0]      p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [SW-1:0]      re_q, im_q;
  logic                      s1_vld_q, s2_vld_q, s3_vld_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic signed [data_bw-1:0] sat_r, sat_i;
  logic                      clip_r, clip_i;
  logic                      sof_d, ovf_d;

  cmul_sat #(.IN_W(SW), .OUT_W(data_bw), .SHIFT(TW_FRAC)) u_sat_r (
    .sum_i (re_q),
    .sat_c (sat_r),
    .clip_c(clip_r)
  );

  cmul_sat #(.IN_W(SW), .OUT_W(data_bw), .SHIFT(TW_FRAC)) u_sat_i (
    .sum_i (im_q),
    .sat_c (sat_i),
    .clip_c(clip_i)
  );

  // Frame position advances once per valid output sample.
  always_comb begin
    cnt_d = cnt_q;
    sof_d = s3_vld_q & (cnt_q == '0);
    ovf_d = ovf_flag | (s3_vld_q & (clip_r | clip_i));
    if (s3_vld_q) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      ar_q     <= '0;
      ai_q     <= '0;
      br_q     <= '0;
      bi_q     <= '0;
      s1_vld_q <= 1'b0;
      p_rr_q   <= '0;
      p_ii_q   <= '0;
      p_ri_q   <= '0;
      p_ir_q   <= '0;
      s2_vld_q <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      s3_vld_q <= 1'b0;
      dout_r   <= '0;
      dout_i   <= '0;
      dout_vld <= 1'b0;
      dout_sof <= 1'b0;
      ovf_flag <= 1'b0;
      cnt_q    <= '0;
    end else if (sys_en) begin
      ar_q     <= al_r;
      ai_q     <= al_i;
      br_q     <= tw_fac_r;
      bi_q     <= tw_fac_i;
      s1_vld_q <= al_vld;
      p_rr_q   <= ar_q * br_q;
      p_ii_q   <= ai_q * bi_q;
      p_ri_q   <= ar_q * bi_q;
      p_ir_q   <= ai_q * br_q;
      s2_vld_q <= s1_vld_q;
      re_q     <= SW'(p_rr_q) - SW'(p_ii_q);
      im_q     <= SW'(p_ri_q) + SW'(p_ir_q);
      s3_vld_q <= s2_vld_q;
      dout_r   <= sat_r;
      dout_i   <= sat_i;
      dout_vld <= s3_vld_q;
      dout_sof <= sof_d;
      ovf_flag <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_twiddle_cmul.sv
// Self-checking bench for twiddle_cmul: directed cases plus randomized traffic against a reference model.
module tb_twiddle_cmul;
  import twiddle_cmul_pkg::*;

  localparam int N = 16;

  logic               sys_clk = 1'b0;
  logic               sys_nrst, sys_en, din_vld, cordic_rdy;
  logic signed [15:0] din_r, din_i, dout_r, dout_i;
  logic signed [16:0] tw_fac_r, tw_fac_i;
  logic               dout_vld, dout_sof, ovf_flag;

  always #5 sys_clk = ~sys_clk;

  twiddle_cmul #(.data_bw(16), .fft_length(N), .align_dly(0)) dut (
    .sys_clk   (sys_clk),
    .sys_nrst  (sys_nrst),
    .sys_en    (sys_en),
    .din_r     (din_r),
    .din_i     (din_i),
    .din_vld   (din_vld),
    .tw_fac_r  (tw_fac_r),
    .tw_fac_i  (tw_fac_i),
    .cordic_rdy(cordic_rdy),
    .dout_r    (dout_r),
    .dout_i    (dout_i),
    .dout_vld  (dout_vld),
    .dout_sof  (dout_sof),
    .ovf_flag  (ovf_flag)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: accepted samples in flight, frame position, sticky overflow.
  bit     rdy_seen;
  int     vcnt;
  bit     qv[$];
  longint qr[$], qi[$], qtr[$], qti[$];
  bit     exp_vld, exp_sof, exp_ovf;
  longint exp_r, exp_i;

  function automatic longint lane(input longint s, output bit clip);
    longint v;
    v = s;
`ifdef TWIDDLE_CMUL_ROUND_EN
    v = v + 64'sd16384;
`endif
    v    = v >>> 15;
    clip = 1'b0;
    if (v > 32767) begin
      v = 32767; clip = 1'b1;
    end else if (v < -32768) begin
      v = -32768; clip = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rdy_seen = 1'b0;
    vcnt     = 0;
    qv.delete(); qr.delete(); qi.delete(); qtr.delete(); qti.delete();
    exp_vld = 1'b0; exp_sof = 1'b0; exp_ovf = 1'b0;
    exp_r   = 0;    exp_i   = 0;
  endtask

  task automatic model_clk(input bit vld, input longint dr, input longint di,
                           input longint tr, input longint ti, input bit rdy);
    bit     v, c1, c2;
    longint ar, ai, br, bi;
    qv.push_back(vld && rdy_seen);
    qr.push_back(dr); qi.push_back(di); qtr.push_back(tr); qti.push_back(ti);
    if (rdy) rdy_seen = 1'b1;
    if (qv.size() == 4) begin
      v  = qv.pop_front();
      ar = qr.pop_front(); ai = qi.pop_front();
      br = qtr.pop_front(); bi = qti.pop_front();
      exp_vld = v;
      exp_sof = 1'b0;
      if (v) begin
        exp_r = lane(ar * br - ai * bi, c1);
        exp_i = lane(ar * bi + ai * br, c2);
        if (c1 || c2) exp_ovf = 1'b1;
        exp_sof = (vcnt == 0);
        vcnt    = (vcnt + 1) % N;
      end
    end
  endtask

  task automatic check_outputs();
    chk("dout_vld", dout_vld, exp_vld);
    chk("dout_sof", dout_sof, exp_sof);
    chk("ovf_flag", ovf_flag, exp_ovf);
    if (exp_vld) begin
      chk("dout_r", dout_r, exp_r);
      chk("dout_i", dout_i, exp_i);
    end
  endtask

  task automatic step(input bit en, input bit vld, input int dr, input int di,
                      input int tr, input int ti, input bit rdy);
    sys_en     = en;
    din_vld    = vld;
    din_r      = 16'(dr);
    din_i      = 16'(di);
    tw_fac_r   = 17'(tr);
    tw_fac_i   = 17'(ti);
    cordic_rdy = rdy;
    @(posedge sys_clk);
    if (en) model_clk(vld, dr, di, tr, ti, rdy);
    #1;
    check_outputs();
  endtask

  function automatic int rv();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int rtw();
    return ($urandom_range(0, 7) == 0) ? TW_ONE : rv();
  endfunction

  task automatic rnd_step(input bit en, input bit vld, input bit rdy);
    step(en, vld, rv(), rv(), rtw(), rtw(), rdy);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) rnd_step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r"}, dout_r, 0);
    chk({tag, "_i"}, dout_i, 0);
    chk({tag, "_vld"}, dout_vld, 0);
    chk({tag, "_sof"}, dout_sof, 0);
    chk({tag, "_ovf"}, ovf_flag, 0);
  endtask

  initial begin
    sys_nrst = 1'b0; sys_en = 1'b1; din_vld = 1'b0; cordic_rdy = 1'b0;
    din_r = '0; din_i = '0; tw_fac_r = '0; tw_fac_i = '0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk_reset_outputs("reset");
    sys_nrst = 1'b1;

    // Twiddle stream not ready: valid input must be dropped.
    for (int k = 0; k < 20; k++) rnd_step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 111, 222, TW_ONE, 0, 1'b1);

    // Identity twiddle; first output of the stream carries sof.
    step(1'b1, 1'b1, 1000, -2000, TW_ONE, 0, 1'b1);
    idle(3);
    chk("t1_r", dout_r, 1000);
    chk("t1_i", dout_i, -2000);
    chk("t1_vld", dout_vld, 1);
    chk("t1_sof", dout_sof, 1);
    chk("t1_ovf", ovf_flag, 0);

    step(1'b1, 1'b1, 1000, 0, 0, -32768, 1'b1);
    idle(3);
    chk("t2a_r", dout_r, 0);
    chk("t2a_i", dout_i, -1000);

    step(1'b1, 1'b1, 10000, 0, 23170, -23170, 1'b1);
    idle(3);
    chk("t2b_i", dout_i, -7071);

    step(1'b1, 1'b1, -32768, -32768, TW_ONE, TW_ONE, 1'b1);
    idle(3);
    chk("t3_r", dout_r, 0);
    chk("t3_i", dout_i, -32768);
    chk("t3_ovf", ovf_flag, 1);

    step(1'b1, 1'b1, 3, 0, 16384, 0, 1'b1);
    idle(3);
`ifdef TWIDDLE_CMUL_ROUND_EN
    chk("t4_r", dout_r, 2);
`else
    chk("t4_r", dout_r, 1);
`endif
    chk("t4_ovf_sticky", ovf_flag, 1);

    // Random traffic with occasional enable drops and valid gaps.
    for (int k = 0; k < 80; k++)
      rnd_step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'b1);
    for (int k = 0; k < 5; k++) rnd_step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) rnd_step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) rnd_step(1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-frame.
    sys_nrst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(posedge sys_clk);
    #1;
    chk_reset_outputs("midrst_hold");
    sys_nrst = 1'b1;

    step(1'b1, 1'b1, 5, 5, TW_ONE, 0, 1'b1);
    for (int k = 0; k < 4; k++) rnd_step(1'b1, 1'b1, 1'b1);
    chk("post_rst_vld", dout_vld, 1);
    chk("post_rst_sof", dout_sof, 1);

    for (int k = 0; k < 60; k++)
      rnd_step($urandom_range(0, 7) != 0, $urandom_range(0, 4) != 0, 1'b1);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
